lane_traffic_ctrl: RTL and testbench

LANE_TRAFFIC_CTRL -- requirements
Module: lane_traffic_ctrl

---
 rtl/lane_traffic_ctrl.sv | 90 +++++++++
 tb/tb_lane_traffic_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_traffic_ctrl.sv
// Per-lane car position engine: every TICK_DIV enabled cycles each lane steps left/right and wraps on the screen width.
// Latency: positions, o_tick and o_wrap are registered and appear one cycle after the tick edge; no backpressure, i_enable pauses.
module lane_traffic_ctrl #(
    parameter int NUM_LANES = 8,
    parameter int X_WIDTH   = 10,
    parameter int SCREEN_W  = 640,
    parameter int SPEED_W   = 4,
    parameter int TICK_DIV  = 250000,
    parameter logic [NUM_LANES*X_WIDTH-1:0] INIT_X =
        {10'd560, 10'd480, 10'd400, 10'd320, 10'd240, 10'd160, 10'd80, 10'd0}
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           i_enable,
    input  logic                           i_restart,
    input  logic [2:0]                     i_level,
    input  logic [NUM_LANES-1:0]           i_lane_dir,
    input  logic [NUM_LANES*SPEED_W-1:0]   i_lane_speed,
    output logic [NUM_LANES*X_WIDTH-1:0]   o_car_x,
    output logic                           o_tick,
    output logic [NUM_LANES-1:0]           o_wrap
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam int STEP_W = SPEED_W + 3;
    localparam int AW     = ((X_WIDTH > STEP_W) ? X_WIDTH : STEP_W) + 1;
    localparam logic [AW-1:0] SCR_A = AW'(SCREEN_W);

    logic [CNT_W-1:0]   cnt;
    logic               tick_edge;
    logic [X_WIDTH-1:0] car_x  [NUM_LANES];
    logic [X_WIDTH-1:0] next_x [NUM_LANES];
    logic [X_WIDTH-1:0] init_x [NUM_LANES];
    logic [NUM_LANES-1:0] next_wrap;

    // Restart wins over a coincident tick, so it also masks the tick pulse.
    assign tick_edge = i_enable && !i_restart && (cnt == CNT_LAST);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [X_WIDTH-1:0] init_raw;
        logic [SPEED_W-1:0] spd;
        logic [STEP_W-1:0]  step;
        logic [AW-1:0]      x_w;
        logic [AW-1:0]      step_w;
        logic [AW-1:0]      sum_r;
        logic               wrap_r;
        logic               wrap_l;

        assign init_raw  = INIT_X[k*X_WIDTH +: X_WIDTH];
        assign init_x[k] = (AW'(init_raw) >= SCR_A) ? '0 : init_raw;

        assign spd    = i_lane_speed[k*SPEED_W +: SPEED_W];
        assign step   = (spd == '0) ? '0 : STEP_W'(spd) + STEP_W'(i_level);
        assign x_w    = AW'(car_x[k]);
        assign step_w = AW'(step);
        assign sum_r  = x_w + step_w;
        assign wrap_r = (sum_r >= SCR_A);
        assign wrap_l = (x_w < step_w);

        assign next_x[k] = i_lane_dir[k]
            ? (wrap_r ? X_WIDTH'(sum_r - SCR_A) : X_WIDTH'(sum_r))
            : (wrap_l ? X_WIDTH'(x_w + SCR_A - step_w) : X_WIDTH'(x_w - step_w));
        assign next_wrap[k] = i_lane_dir[k] ? wrap_r : wrap_l;

        assign o_car_x[k*X_WIDTH +: X_WIDTH] = car_x[k];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            o_tick <= 1'b0;
            o_wrap <= '0;
            for (int k = 0; k < NUM_LANES; k++) car_x[k] <= init_x[k];
        end else if (i_restart) begin
            cnt    <= '0;
            o_tick <= 1'b0;
            o_wrap <= '0;
            for (int k = 0; k < NUM_LANES; k++) car_x[k] <= init_x[k];
        end else begin
            o_tick <= tick_edge;
            o_wrap <= tick_edge ? next_wrap : '0;
            if (i_enable) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            if (tick_edge) begin
                for (int k = 0; k < NUM_LANES; k++) car_x[k] <= next_x[k];
            end
        end
    end

endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// Bench for lane_traffic_ctrl: directed scenarios plus randomized traffic against a modular-arithmetic reference model.
module tb_lane_traffic_ctrl;

    localparam int NL  = 8;
    localparam int XW  = 10;
    localparam int SW  = 640;
    localparam int SPW = 4;
    localparam int TD  = 4;
    localparam logic [NL*XW-1:0] INIT =
        {10'd1000, 10'd320, 10'd0, 10'd639, 10'd300, 10'd100, 10'd2, 10'd636};
    localparam int INIT_EXP [NL] = '{636, 2, 100, 300, 639, 0, 320, 0};

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            i_enable = 1'b0;
    logic            i_restart = 1'b0;
    logic [2:0]      i_level = '0;
    logic [NL-1:0]   i_lane_dir = '0;
    logic [NL*SPW-1:0] i_lane_speed = '0;
    logic [NL*XW-1:0]  o_car_x;
    logic            o_tick;
    logic [NL-1:0]   o_wrap;

    lane_traffic_ctrl #(
        .NUM_LANES(NL), .X_WIDTH(XW), .SCREEN_W(SW), .SPEED_W(SPW),
        .TICK_DIV(TD), .INIT_X(INIT)
    ) dut (
        .CLK(CLK), .RST(RST), .i_enable(i_enable), .i_restart(i_restart),
        .i_level(i_level), .i_lane_dir(i_lane_dir), .i_lane_speed(i_lane_speed),
        .o_car_x(o_car_x), .o_tick(o_tick), .o_wrap(o_wrap)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: positions as plain integers, ticks from a count of enabled cycles.
    int          mx [NL];
    int          en_cnt;
    logic        exp_tick;
    logic [NL-1:0] exp_wrap;

    task automatic check(input string tag, input logic [NL*XW-1:0] obs, input logic [NL*XW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NL; k++) mx[k] = INIT_EXP[k];
        en_cnt   = 0;
        exp_tick = 1'b0;
        exp_wrap = '0;
    endtask

    task automatic model_tick();
        for (int k = 0; k < NL; k++) begin
            int spd, step, raw;
            spd  = int'(i_lane_speed[k*SPW +: SPW]);
            step = (spd == 0) ? 0 : spd + int'(i_level);
            raw  = i_lane_dir[k] ? mx[k] + step : mx[k] - step;
            exp_wrap[k] = (raw >= SW) || (raw < 0);
            mx[k] = ((raw % SW) + SW) % SW;
        end
        exp_tick = 1'b1;
    endtask

    task automatic model_edge();
        exp_tick = 1'b0;
        exp_wrap = '0;
        if (RST || i_restart) begin
            model_reset();
        end else if (i_enable) begin
            en_cnt++;
            if (en_cnt % TD == 0) model_tick();
        end
    endtask

    function automatic logic [NL*XW-1:0] model_flat();
        logic [NL*XW-1:0] f;
        for (int k = 0; k < NL; k++) f[k*XW +: XW] = XW'(mx[k]);
        return f;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_tick"}, {{(NL*XW-1){1'b0}}, o_tick}, {{(NL*XW-1){1'b0}}, exp_tick});
        check({tag, "_wrap"}, {{(NL*XW-NL){1'b0}}, o_wrap}, {{(NL*XW-NL){1'b0}}, exp_wrap});
        check({tag, "_carx"}, o_car_x, model_flat());
    endtask

    task automatic cyc(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    function automatic logic [XW-1:0] lane_x(input int k);
        return o_car_x[k*XW +: XW];
    endfunction

    initial begin
        logic [NL*XW-1:0] init_flat;
        for (int k = 0; k < NL; k++) init_flat[k*XW +: XW] = XW'(INIT_EXP[k]);

        #1 RST = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        check("reset_clamp", o_car_x, init_flat);
        cyc("reset_hold");
        cyc("reset_hold");
        RST = 1'b0;

        // Right wrap on the very first tick: lane 0 636 + (3+2) -> 1.
        i_enable = 1'b1;
        i_level  = 3'd2;
        i_lane_dir = 8'b0000_0001;
        i_lane_speed = 32'h0000_0003;
        for (int i = 1; i <= TD; i++) begin
            cyc("first_tick");
            check("first_tick_timing", {79'd0, o_tick}, {79'd0, (i == TD)});
        end
        check("rwrap_x", {70'd0, lane_x(0)}, 80'd1);
        check("rwrap_flag", {79'd0, o_wrap[0]}, 80'd1);

        // Left wrap at level 0: lane 1 2 - 4 -> 638, then 634.
        i_restart = 1'b1;
        cyc("restart");
        i_restart = 1'b0;
        i_level = 3'd0;
        i_lane_dir = 8'b0000_0000;
        i_lane_speed = 32'h0000_0040;
        for (int i = 0; i < TD; i++) cyc("lwrap");
        check("lwrap_x", {70'd0, lane_x(1)}, 80'd638);
        check("lwrap_flag", {79'd0, o_wrap[1]}, 80'd1);
        for (int i = 0; i < TD; i++) cyc("lwrap2");
        check("lwrap2_x", {70'd0, lane_x(1)}, 80'd634);
        check("lwrap2_flag", {79'd0, o_wrap[1]}, 80'd0);

        // Speed 0 at level 7 never moves lane 2 across ten ticks.
        i_level = 3'd7;
        for (int i = 0; i < 10 * TD; i++) begin
            cyc("spd0");
            check("spd0_nowrap", {79'd0, o_wrap[2]}, 80'd0);
        end
        check("spd0_x", {70'd0, lane_x(2)}, 80'd100);

        // Pause at count 2 for 100 cycles, then the tick lands two cycles after resume.
        for (int i = 0; i < TD && (en_cnt % TD) != 2; i++) cyc("to_pause");
        i_enable = 1'b0;
        for (int i = 0; i < 100; i++) cyc("pause");
        i_enable = 1'b1;
        cyc("resume1");
        check("resume1_tick", {79'd0, o_tick}, 80'd0);
        cyc("resume2");
        check("resume2_tick", {79'd0, o_tick}, 80'd1);

        // Restart coinciding with a tick edge.
        for (int i = 0; i < TD && (en_cnt % TD) != TD - 1; i++) cyc("to_restart");
        i_restart = 1'b1;
        cyc("restart_tick");
        check("restart_tick_none", {79'd0, o_tick}, 80'd0);
        check("restart_tick_init", o_car_x, init_flat);
        i_restart = 1'b0;

        // Randomized traffic; inputs change every cycle so only tick-edge values matter.
        for (int i = 0; i < 600; i++) begin
            i_enable     = ($urandom_range(0, 7) != 0);
            i_restart    = ($urandom_range(0, 59) == 0);
            i_level      = 3'($urandom_range(0, 7));
            i_lane_dir   = 8'($urandom);
            i_lane_speed = $urandom;
            cyc("rand");
        end

        // Asynchronous reset between edges, partial count discarded.
        i_restart = 1'b0;
        i_enable  = 1'b1;
        i_lane_speed = 32'h1111_1111;
        for (int i = 0; i < 2; i++) cyc("pre_arst");
        #2 RST = 1'b1;
        model_reset();
        #1;
        check_all("arst");
        check("arst_init", o_car_x, init_flat);
        cyc("arst_hold");
        RST = 1'b0;
        for (int i = 1; i <= 3 * TD; i++) begin
            cyc("post_arst");
            check("post_arst_timing", {79'd0, o_tick}, {79'd0, (i % TD == 0)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
